// File: rtl/jt12_seq_pkg.sv
// Shared types and register map constants for the jt12 bus sequencer.
package jt12_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_A_WR, S_A_GAP, S_D_WR, S_D_GAP, S_WAIT
  } seq_state_t;

  typedef struct packed {
    logic [7:0] reg_idx;
    logic [7:0] val;
  } seq_entry_t;

  localparam logic [7:0] DTMUL     = 8'h30;
  localparam logic [7:0] TL        = 8'h40;
  localparam logic [7:0] KSAR      = 8'h50;
  localparam logic [7:0] DR        = 8'h60;
  localparam logic [7:0] SR        = 8'h70;
  localparam logic [7:0] SLRR      = 8'h80;
  localparam logic [7:0] FBCON     = 8'hB0;
  localparam logic [7:0] KEYON     = 8'h28;
  localparam logic [7:0] TIMER_CTL = 8'h27;

  // Operator slots are not in numeric order inside a channel's register group.
  localparam logic [3:0][7:0] OP_OFS = {8'h0C, 8'h04, 8'h08, 8'h00};

  function automatic logic [7:0] op_reg(input logic [7:0] base, input logic [1:0] ch,
                                        input logic [1:0] op);
    return base + OP_OFS[op] + {6'd0, ch};
  endfunction

endpackage

// File: rtl/jt12_seq_fifo.sv
// Synchronous {reg,val} FIFO with push/pop/flush and occupancy count.
module jt12_seq_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [15:0]   din,
  output logic [15:0]   dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  // A push racing a flush is dropped along with the queued entries.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/jt12_bus_sequencer.sv
// Replays queued (reg,val) pairs as jt12 two-phase CPU bus writes.
// Define JT12_SEQ_BUSY_POLL_EN to replace the fixed hold-off with a status-bit poll.
module jt12_bus_sequencer
  import jt12_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int WR_PULSE = 1,
  parameter int GAP      = 1,
  parameter int HOLD     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_reg,
  input  logic [7:0]    in_val,
  input  logic          flush,
  output logic [7:0]    chip_din,
  output logic          chip_addr,
  output logic          chip_cs_n,
  output logic          chip_wr_n,
  input  logic [7:0]    chip_dout,
  output logic          busy,
  output logic [AW:0]   level,
  output logic          timeout
);

  localparam logic [7:0] PULSE_N = 8'(WR_PULSE - 1);
  localparam logic [7:0] GAP_N   = 8'(GAP - 1);
  localparam logic [7:0] HOLD_N  = 8'(HOLD - 1);

  seq_state_t  state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  seq_entry_t  ent_q, ent_nx;
  logic [15:0] fifo_dout;
  logic        fifo_full, fifo_empty, pop;
  logic        cs_nx, wr_nx, addr_nx;
  logic [7:0]  din_nx;

  jt12_seq_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .flush (flush),
    .din   ({in_reg, in_val}),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = !fifo_empty || (state != S_IDLE);

`ifdef JT12_SEQ_BUSY_POLL_EN
  logic to_q, to_nx;
  assign timeout = to_q;
`else
  logic unused_dout;
  assign unused_dout = ^chip_dout;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ent_nx   = ent_q;
    pop      = 1'b0;
`ifdef JT12_SEQ_BUSY_POLL_EN
    to_nx    = to_q;
`endif
    case (state)
      S_IDLE: if (!fifo_empty) begin
        pop      = 1'b1;
        ent_nx   = seq_entry_t'(fifo_dout);
        state_nx = S_A_WR;
        cnt_nx   = PULSE_N;
      end
      S_A_WR: if (cnt == '0) begin
        state_nx = S_A_GAP;
        cnt_nx   = GAP_N;
      end else cnt_nx = cnt - 8'd1;
      S_A_GAP: if (cnt == '0) begin
        state_nx = S_D_WR;
        cnt_nx   = PULSE_N;
      end else cnt_nx = cnt - 8'd1;
      S_D_WR: if (cnt == '0) begin
        state_nx = S_D_GAP;
        cnt_nx   = GAP_N;
      end else cnt_nx = cnt - 8'd1;
      S_D_GAP: if (cnt == '0) begin
        state_nx = S_WAIT;
        cnt_nx   = HOLD_N;
      end else cnt_nx = cnt - 8'd1;
      S_WAIT: begin
`ifdef JT12_SEQ_BUSY_POLL_EN
        // Status bit is trusted only from the third poll cycle on.
        if (cnt == '0) begin
          state_nx = S_IDLE;
          to_nx    = to_q | chip_dout[7];
        end else if (!chip_dout[7] && (({1'b0, cnt} + 9'd2) <= {1'b0, HOLD_N}))
          state_nx = S_IDLE;
        else
          cnt_nx = cnt - 8'd1;
`else
        if (cnt == '0) state_nx = S_IDLE;
        else           cnt_nx   = cnt - 8'd1;
`endif
      end
      default: state_nx = S_IDLE;
    endcase

    // Bus pins are decoded from the next state so they move with the state register.
    cs_nx   = 1'b1;
    wr_nx   = 1'b1;
    addr_nx = 1'b0;
    din_nx  = chip_din;
    case (state_nx)
      S_A_WR:  begin cs_nx = 1'b0; wr_nx = 1'b0; din_nx = ent_nx.reg_idx; end
      S_A_GAP: begin cs_nx = 1'b0; din_nx = ent_nx.reg_idx; end
      S_D_WR:  begin cs_nx = 1'b0; wr_nx = 1'b0; addr_nx = 1'b1; din_nx = ent_nx.val; end
      S_D_GAP: begin cs_nx = 1'b0; addr_nx = 1'b1; din_nx = ent_nx.val; end
`ifdef JT12_SEQ_BUSY_POLL_EN
      S_WAIT:  cs_nx = 1'b0;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ent_q     <= '0;
      chip_cs_n <= 1'b1;
      chip_wr_n <= 1'b1;
      chip_addr <= 1'b0;
      chip_din  <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ent_q     <= ent_nx;
      chip_cs_n <= cs_nx;
      chip_wr_n <= wr_nx;
      chip_addr <= addr_nx;
      chip_din  <= din_nx;
    end
  end

`ifdef JT12_SEQ_BUSY_POLL_EN
  always_ff @(posedge clk) begin
    if (rst) to_q <= 1'b0;
    else     to_q <= to_nx;
  end
`endif

endmodule

// File: tb/tb_jt12_bus_sequencer.sv
// Randomized bench for jt12_bus_sequencer against a queue/timeline reference model.
module tb_jt12_bus_sequencer;
  import jt12_seq_pkg::*;

  localparam int DEPTH = 16, AW = 4, WP = 1, G = 1, HOLD = 32;
`ifdef JT12_SEQ_BUSY_POLL_EN
  localparam bit POLL = 1'b1;
`else
  localparam bit POLL = 1'b0;
`endif
  // With status held clear, a poll always lasts its 3 minimum cycles.
  localparam int WAITN = POLL ? 3 : HOLD;
  localparam int P     = 2*(WP+G) + WAITN + 1;

  logic clk, rst, in_valid, in_ready, flush, chip_addr, chip_cs_n, chip_wr_n, busy, timeout;
  logic [7:0] in_reg, in_val, chip_din, chip_dout;
  logic [AW:0] level;

  jt12_bus_sequencer #(.DEPTH(DEPTH), .AW(AW), .WR_PULSE(WP), .GAP(G), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg),
    .in_val(in_val), .flush(flush), .chip_din(chip_din), .chip_addr(chip_addr),
    .chip_cs_n(chip_cs_n), .chip_wr_n(chip_wr_n), .chip_dout(chip_dout), .busy(busy),
    .level(level), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: queue of entries plus offset of the current write from its pop cycle.
  logic [15:0] q[$];
  bit          m_act = 1'b0;
  int          off   = 0;
  logic [15:0] cur   = '0;
  bit          m_to  = 1'b0;

  task automatic check_now();
    logic ecs, ewr, ea, cd;
    logic [7:0] ed;
    ecs = 1'b1; ewr = 1'b1; ea = 1'b0; cd = 1'b0; ed = '0;
    if (m_act) begin
      if (off <= WP)              begin ecs = 0; ewr = 0; ed = cur[15:8]; cd = 1; end
      else if (off <= WP+G)       begin ecs = 0; ed = cur[15:8]; cd = 1; end
      else if (off <= 2*WP+G)     begin ecs = 0; ewr = 0; ea = 1; ed = cur[7:0]; cd = 1; end
      else if (off <= 2*WP+2*G)   begin ecs = 0; ea = 1; ed = cur[7:0]; cd = 1; end
      else ecs = !POLL;
    end
    chk("cs_n", chip_cs_n, ecs);
    chk("wr_n", chip_wr_n, ewr);
    chk("addr", chip_addr, ea);
    if (cd) chk("din", chip_din, ed);
    chk("level", level, q.size());
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("busy", busy, m_act || q.size() != 0);
    chk("timeout", timeout, m_to);
  endtask

  task automatic model_step(input logic v, input logic [7:0] r, input logic [7:0] d,
                            input logic f, input logic rs);
    bit ready;
    if (rs) begin
      q.delete(); m_act = 0; off = 0; m_to = 0;
      return;
    end
    ready = q.size() < DEPTH;
    if (!m_act) begin
      if (q.size() > 0) begin cur = q.pop_front(); m_act = 1; off = 1; end
    end else begin
      off++;
      if (off == P) m_act = 0;
    end
    if (f) q.delete();
    else if (v && ready) q.push_back({r, d});
  endtask

  task automatic cycle(input logic v, input logic [7:0] r, input logic [7:0] d,
                       input logic f, input logic rs);
    @(negedge clk);
    check_now();
    in_valid = v; in_reg = r; in_val = d; flush = f; rst = rs;
    model_step(v, r, d, f, rs);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 8'h00, 8'h00, 0, 0);
  endtask

`ifdef JT12_SEQ_BUSY_POLL_EN
  // Raw-driven write whose poll sees bit7 set for the first `ones` poll cycles.
  task automatic poll_run(input int ones, output int len);
    @(negedge clk);
    in_valid = 1; in_reg = KEYON; in_val = 8'hF0;
    @(negedge clk);
    in_valid = 0;
    chip_dout = 8'h80;
    for (int i = 0; i < 40 && !(chip_cs_n == 0 && chip_wr_n == 1 && chip_addr == 1); i++)
      @(negedge clk);
    @(negedge clk);
    len = 0;
    for (int i = 0; i < 300 && chip_cs_n == 0; i++) begin
      len++;
      chip_dout = (len <= ones) ? 8'h80 : 8'h00;
      @(negedge clk);
    end
    chip_dout = 8'h00;
  endtask
`endif

  logic [7:0] tdin [4] = '{8'h27, 8'h27, 8'h3B, 8'h3B};
  logic       taddr[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       twr  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       pv;
  logic [7:0] rr;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; in_valid = 0; in_reg = 0; in_val = 0; flush = 0; chip_dout = 0;

    // Reset state
    cycle(0, 0, 0, 0, 1);
    #1 chk("rst_din", chip_din, 8'h00);
    chk("rst_cs_n", chip_cs_n, 1'b1);

    // Single write, cycle-by-cycle bus trace
    cycle(1, 8'h27, 8'h3B, 0, 0);
    #1 chk("t1_level", level, 1);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      #1 chk("t_din", chip_din, tdin[k]);
      chk("t_addr", chip_addr, taddr[k]);
      chk("t_wr_n", chip_wr_n, twr[k]);
      chk("t_cs_n", chip_cs_n, 1'b0);
    end
    idle(1);
    #1 chk("t_cs6", chip_cs_n, !POLL);
    idle(P - 6);
    #1 chk("t_busy_last", busy, 1'b1);
    idle(1);
    #1 chk("t_busy_done", busy, 1'b0);

    // 17 pushes behind a busy write: 16 fit, 17th lost, key-on last out
    cycle(1, TIMER_CTL, 8'h15, 0, 0);
    for (int i = 0; i < 17; i++) begin
      if (i < 15)       cycle(1, op_reg(TL, 2'(i % 3), 2'(i % 4)), 8'(i), 0, 0);
      else if (i == 15) cycle(1, KEYON, 8'hF0, 0, 0);
      else              cycle(1, 8'hAA, 8'h55, 0, 0);
    end
    #1 chk("fill_level", level, q.size());
    chk("fill_ready", in_ready, q.size() < DEPTH);
    idle(16 * P + 10);

    // Push coinciding with pop at full, then at level 5
    cycle(1, DTMUL, 8'h01, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, op_reg(KSAR, 2'(i % 3), 2'(i % 4)), 8'(i + 32), 0, 0);
    for (int i = 0; i < 60; i++) begin
      pv = !m_act && q.size() == DEPTH;
      cycle(pv, 8'h11, 8'h22, 0, 0);
      if (pv) begin #1 chk("full_pp_level", level, DEPTH - 1); end
    end
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, op_reg(DR, 2'(i % 3), 2'(i % 4)), 8'(i + 64), 0, 0);
    for (int i = 0; i < 60; i++) begin
      pv = !m_act && q.size() == 5;
      cycle(pv, 8'h33, 8'h44, 0, 0);
      if (pv) begin #1 chk("pp5_level", level, 5); end
    end
    cycle(0, 0, 0, 1, 0);
    idle(P + 5);

    // Reset during the data-phase write pulse
    cycle(1, SR, 8'h0F, 0, 0);
    for (int i = 0; i < 20 && !(m_act && off == WP + G + 1); i++) idle(1);
    chk("rst_found_dwr", m_act && off == WP + G + 1, 1'b1);
    cycle(1, SLRR, 8'h99, 0, 1);
    #1 chk("rst_mid_cs_n", chip_cs_n, 1'b1);
    chk("rst_mid_wr_n", chip_wr_n, 1'b1);
    chk("rst_mid_level", level, 0);
    chk("rst_mid_busy", busy, 1'b0);
    cycle(1, FBCON, 8'h07, 0, 0);
    idle(P + 5);

    // Flush at level 8 while the second write sits in its address gap
    cycle(1, op_reg(SLRR, 0, 0), 8'hF1, 0, 0);
    for (int i = 0; i < 9; i++) cycle(1, op_reg(SLRR, 2'(i % 3), 2'(i % 4)), 8'(i + 96), 0, 0);
    for (int i = 0; i < 60 && !(m_act && off == WP + 1 && q.size() == 8); i++) idle(1);
    cycle(0, 0, 0, 1, 0);
    #1 chk("flush_level", level, 0);
    idle(P + 10);
    #1 chk("flush_idle_busy", busy, 1'b0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 800; i++) begin
      rr = 8'($urandom);
      cycle($urandom_range(0, 2) == 0, rr, 8'($urandom),
            $urandom_range(0, 63) == 0, $urandom_range(0, 299) == 0);
    end
    idle(17 * P + 5);

`ifdef JT12_SEQ_BUSY_POLL_EN
    begin
      int len;
      poll_run(10, len);
      chk("poll_len_10", len, 11);
      chk("poll_to_0", timeout, 1'b0);
      poll_run(100000, len);
      chk("poll_len_hold", len, HOLD);
      chk("poll_to_1", timeout, 1'b1);
      m_to = 1;
      cycle(0, 0, 0, 0, 1);
      idle(2);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jt12_bus_sequencer.md
Name: jt12_bus_sequencer

Overview:
- Upstream feeder for the jt12 top CPU port.
- Accepts queued (register, value) pairs and replays each one as the chip's two-phase bus write:
  - address phase: addr=0, din=register
  - data phase: addr=1, din=value
- Enforces write pulse width, inter-phase gap and post-write hold-off.
- Replaces hand-timed bus stimulus; also used as the register loader in system builds.

Parameters:
- DEPTH, 16, FIFO entries (power of two).
- AW, 4, log2(DEPTH).
- WR_PULSE, 1, cycles wr_n held low per phase (1..15).
- GAP, 1, cycles wr_n held high after each phase (1..15).
- HOLD, 32, post-data-write hold-off cycles (1..255); in the fixed-hold build, cycles before the next entry may start.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, push request.
- in_ready, output, 1, FIFO not full.
- in_reg, input, 8, register index.
- in_val, input, 8, register value.
- flush, input, 1, discard all queued entries.
- chip_din, output, 8, to top din.
- chip_addr, output, 1, to top addr.
- chip_cs_n, output, 1, to top cs_n.
- chip_wr_n, output, 1, to top wr_n.
- chip_dout, input, 8, from top dout (status).
- busy, output, 1, FIFO non-empty or FSM not IDLE.
- level, output, AW+1, FIFO occupancy.
- timeout, output, 1, sticky poll-timeout flag (tied 0 without the option).

Behaviour:
- Reset values:
  - chip_cs_n=1, chip_wr_n=1, chip_addr=0, chip_din=0.
  - level=0, in_ready=1, busy=0, timeout=0, FSM=IDLE.
  - rst mid-operation aborts the sequence; outputs return to reset values on the next edge; FIFO is emptied.
- Handshake:
  - A push occurs on an edge where in_valid && in_ready.
  - The entry is visible (level increments) the following cycle.
  - A push while full is ignored; in_ready is 0 when level==DEPTH.
  - Simultaneous push and pop at full is refused; at any other level, level is unchanged.
  - Pointers wrap modulo DEPTH.
- flush empties the FIFO on the next edge and does not abort an in-flight write. Push in the same cycle as flush is dropped.
- FSM, with all outputs registered and changing on the same edge as the state:
  - IDLE: cs_n=1, wr_n=1. If FIFO non-empty: pop the head, go to A_WR.
  - A_WR: cs_n=0, wr_n=0, addr=0, din=reg, for WR_PULSE cycles, then A_GAP.
  - A_GAP: cs_n=0, wr_n=1, addr=0, din held, for GAP cycles, then D_WR.
  - D_WR: cs_n=0, wr_n=0, addr=1, din=val, for WR_PULSE cycles, then D_GAP.
  - D_GAP: cs_n=0, wr_n=1, addr=1, for GAP cycles, then WAIT.
  - WAIT: cs_n=1, wr_n=1, addr=0, for HOLD cycles, then IDLE.
- Per-write period = 2*(WR_PULSE+GAP)+HOLD+1 cycles, counting from the IDLE pop cycle.
- One 8-bit down-counter is shared by all timed states; it is loaded with N-1 on state entry.
- cs_n is never low while wr_n toggles without a valid addr/din; addr and din are stable throughout each wr_n-low window.

Optional Feature:
- Macro: JT12_SEQ_BUSY_POLL_EN.
- With the macro, WAIT becomes POLL:
  - Outputs: cs_n=0, wr_n=1, addr=0.
  - chip_dout[7] is sampled each cycle. The first 2 POLL cycles are always spent (status latency).
  - Exit to IDLE on the first later cycle with chip_dout[7]==0.
  - If bit7 is still 1 after HOLD cycles: set timeout (sticky until rst) and exit to IDLE anyway.
- Without the macro: fixed HOLD wait, chip_dout is unused, timeout is tied 0.

Decomposition:
- Package jt12_seq_pkg holds:
  - the state enum;
  - register base constants: DTMUL 8'h30, TL 8'h40, KSAR 8'h50, DR 8'h60, SR 8'h70, SLRR 8'h80, FBCON 8'hB0, KEYON 8'h28, TIMER_CTL 8'h27;
  - operator offsets 0,8,4,C.
- Sub-module jt12_seq_fifo: synchronous FIFO, 16-bit wide {reg,val}, DEPTH deep, with push/pop/flush/level.

Test Plan:
- Single push (27,3B), defaults: pop in cycle 1, then cycles 2-5 show A_WR/A_GAP/D_WR/D_GAP with din 27,27,3B,3B, addr 0,0,1,1, wr_n 0,1,0,1; cs_n high from cycle 6; busy low at cycle 38.
- Push 17 entries back-to-back: level reaches 16, in_ready drops, 17th entry lost; all 16 emerge in order (key-on 28/F0 last).
- At full, push and pop in the same cycle: push refused, level 15 next cycle; push and pop at level 5: level stays 5.
- Assert rst during D_WR: next cycle cs_n=1, wr_n=1, level=0, busy=0; a new push afterwards is written normally.
- flush at level 8 during A_GAP: the current write completes, level=0, no further writes.
- JT12_SEQ_BUSY_POLL_EN, chip_dout[7]=1 for 10 cycles: POLL lasts 11 cycles, timeout stays 0. Held at 1 with HOLD=32: exit after 32 cycles and timeout=1.
